// File: rtl/tdm_channel_mux_if.sv
// tdm_channel_mux_if
//   Bundles the producer write ports and the consumer output handshake of
//   tdm_channel_mux.
//   slave  : seen by the mux (takes writes, drives the output word).
//   master : seen by whoever feeds the producers and consumes the output.
//   Signals:
//     wr_en[CHANNELS], wr_data[CHANNELS*WIDTH]  per-channel writes (channel i in [i*WIDTH +: WIDTH])
//     wr_full[CHANNELS], ovf[CHANNELS]          per-channel full / sticky overflow
//     clr_ovf                                   clears all ovf bits
//     out_data, out_chan, out_valid, out_ready  forwarded word with source tag
interface tdm_channel_mux_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       wr_en;
    logic [CHANNELS*WIDTH-1:0] wr_data;
    logic [CHANNELS-1:0]       wr_full;
    logic [CHANNELS-1:0]       ovf;
    logic                      clr_ovf;
    logic [WIDTH-1:0]          out_data;
    logic [CW-1:0]             out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output wr_en, wr_data, clr_ovf, out_ready,
        input  wr_full, ovf, out_data, out_chan, out_valid
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, out_ready,
        output wr_full, ovf, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/tdm_channel_mux.sv
// tdm_channel_mux
//   N-channel time-division capture/forward block. Each producer channel
//   writes into its own DEPTH-entry FIFO; a round-robin slot scheduler
//   forwards one word per load cycle into a single registered output.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; discards all buffered words
//     bus    tdm_channel_mux_if.slave (write ports, flags, output handshake)
//   Parameters: WIDTH, CHANNELS, DEPTH, SKIP_IDLE (0 = fixed slots,
//   1 = work-conserving round robin).

// Per-channel holding FIFO. full/empty come from the registered count only,
// so a write to a full channel is dropped even if that channel is popped
// on the same edge.
module tdm_chan_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic [WIDTH-1:0] head
);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    rd_idx, wr_idx;
    logic [CNTW-1:0]  count;
    logic             push, pop_ok;

    // Indices wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    assign full   = (count == CNTW'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_en && !full;
    assign drop   = wr_en && full;
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_idx];

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_idx <= idx_inc(wr_idx);
            if (pop_ok) rd_idx <= idx_inc(rd_idx);
            if (push && !pop_ok)      count <= count + CNTW'(1);
            else if (pop_ok && !push) count <= count - CNTW'(1);
        end
    end
endmodule

module tdm_channel_mux #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 2,
    parameter int SKIP_IDLE = 0
) (
    input logic              clk,
    input logic              reset,
    tdm_channel_mux_if.slave bus
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]            empty, full, drop, pop;
    logic [CHANNELS-1:0][WIDTH-1:0] head;
    logic [CW-1:0]                  ptr, ptr_nxt, gnt, cand;
    logic                           gnt_vld, load;
    logic [WIDTH-1:0]               out_data_q;
    logic [CW-1:0]                  out_chan_q;
    logic                           out_valid_q;
    logic [CHANNELS-1:0]            ovf_q;

    function automatic logic [CW-1:0] chan_inc(input logic [CW-1:0] p);
        return (p == CW'(CHANNELS - 1)) ? '0 : p + CW'(1);
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        tdm_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (bus.wr_en[i]),
            .wr_data(bus.wr_data[i*WIDTH +: WIDTH]),
            .pop    (pop[i]),
            .full   (full[i]),
            .empty  (empty[i]),
            .drop   (drop[i]),
            .head   (head[i])
        );
    end

    // The output register only moves when it is empty or being consumed.
    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        gnt     = ptr;
        gnt_vld = 1'b0;
        ptr_nxt = ptr;
        cand    = ptr;
        if (SKIP_IDLE == 0) begin
            // Fixed slot: the slot is spent even when its channel is empty.
            gnt_vld = !empty[ptr];
            ptr_nxt = chan_inc(ptr);
        end else begin
            // First non-empty channel at or after ptr; ptr only moves on a grant.
            for (int k = 0; k < CHANNELS; k++) begin
                if (!gnt_vld && !empty[cand]) begin
                    gnt     = cand;
                    gnt_vld = 1'b1;
                end
                cand = chan_inc(cand);
            end
            if (gnt_vld) ptr_nxt = chan_inc(gnt);
        end
    end

    always_comb begin
        pop = '0;
        if (load && gnt_vld) pop[gnt] = 1'b1;
    end

    // Emptiness is pre-edge state, so a word written this edge cannot be
    // forwarded until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else if (load) begin
            ptr         <= ptr_nxt;
            out_valid_q <= gnt_vld;
            if (gnt_vld) begin
                out_data_q <= head[gnt];
                out_chan_q <= gnt;
            end
        end
    end

    // A drop on the same edge as clr_ovf keeps its bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= (bus.clr_ovf ? '0 : ovf_q) | drop;
    end

    assign bus.wr_full   = full;
    assign bus.ovf       = ovf_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_tdm_channel_mux.sv
// tb_tdm_channel_mux
//   Drives a fixed-slot (dut0) and a work-conserving (dut1) instance with the
//   same stimulus. Directed scenarios check hand-derived values; a random
//   phase compares both against a queue-based reference model.
module tb_tdm_channel_mux;
    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 2;
    localparam int CW       = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [CHANNELS-1:0]       wr_en     = '0;
    logic [CHANNELS*WIDTH-1:0] wr_data   = '0;
    logic                      clr_ovf   = 1'b0;
    logic                      out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    tdm_channel_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) if_fix ();
    tdm_channel_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) if_wc ();

    assign if_fix.wr_en     = wr_en;
    assign if_fix.wr_data   = wr_data;
    assign if_fix.clr_ovf   = clr_ovf;
    assign if_fix.out_ready = out_ready;
    assign if_wc.wr_en      = wr_en;
    assign if_wc.wr_data    = wr_data;
    assign if_wc.clr_ovf    = clr_ovf;
    assign if_wc.out_ready  = out_ready;

    tdm_channel_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .SKIP_IDLE(0)) u_fix (
        .clk(clk), .reset(reset), .bus(if_fix));
    tdm_channel_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .SKIP_IDLE(1)) u_wc (
        .clk(clk), .reset(reset), .bus(if_wc));

    logic                d_valid [2];
    logic [WIDTH-1:0]    d_data  [2];
    logic [CW-1:0]       d_chan  [2];
    logic [CHANNELS-1:0] d_full  [2];
    logic [CHANNELS-1:0] d_ovf   [2];

    assign d_valid[0] = if_fix.out_valid;
    assign d_data[0]  = if_fix.out_data;
    assign d_chan[0]  = if_fix.out_chan;
    assign d_full[0]  = if_fix.wr_full;
    assign d_ovf[0]   = if_fix.ovf;
    assign d_valid[1] = if_wc.out_valid;
    assign d_data[1]  = if_wc.out_data;
    assign d_chan[1]  = if_wc.out_chan;
    assign d_full[1]  = if_wc.wr_full;
    assign d_ovf[1]   = if_wc.ovf;

    // Reference model: one queue per channel, output word, slot pointer.
    logic [WIDTH-1:0]    mq    [2][CHANNELS][$];
    logic                mv    [2];
    logic [WIDTH-1:0]    md    [2];
    int                  mc    [2];
    logic [CHANNELS-1:0] movf  [2];
    int                  mptr  [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < CHANNELS; c++) mq[m][c].delete();
                mv[m] = 1'b0; md[m] = '0; mc[m] = 0; movf[m] = '0; mptr[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int g;
                logic [CHANNELS-1:0] pf;
                for (int c = 0; c < CHANNELS; c++) pf[c] = (mq[m][c].size() == DEPTH);
                if (!mv[m] || out_ready) begin
                    g = -1;
                    if (m == 0) begin
                        if (mq[m][mptr[m]].size() > 0) g = mptr[m];
                        mptr[m] = (mptr[m] + 1) % CHANNELS;
                    end else begin
                        for (int k = 0; k < CHANNELS; k++)
                            if (g < 0 && mq[m][(mptr[m] + k) % CHANNELS].size() > 0)
                                g = (mptr[m] + k) % CHANNELS;
                        if (g >= 0) mptr[m] = (g + 1) % CHANNELS;
                    end
                    mv[m] = (g >= 0);
                    if (g >= 0) begin
                        md[m] = mq[m][g].pop_front();
                        mc[m] = g;
                    end
                end
                if (clr_ovf) movf[m] = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (wr_en[c]) begin
                        if (pf[c]) movf[m][c] = 1'b1;
                        else       mq[m][c].push_back(wr_data[c*WIDTH +: WIDTH]);
                    end
                end
            end
        end
    end

    // Returns just after a rising edge, with reset released; the next edge is E0.
    task automatic do_reset();
        wr_en = '0; clr_ovf = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wr_en = '1;
            for (int c = 0; c < CHANNELS; c++) wr_data[c*WIDTH +: WIDTH] = 16'($urandom);
            @(posedge clk); #1;
        end
        wr_en = '0;
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (d_valid[m] !== 1'b1 || d_ovf[m] === '0 || d_full[m] === '0) begin
                n_fail++;
                $display("FAIL reset_precond dut%0d: got v=%0b ovf=%b full=%b, expected v=1 ovf/full nonzero",
                         m, d_valid[m], d_ovf[m], d_full[m]);
            end
        end
        reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (d_valid[m] !== 1'b0 || d_data[m] !== '0 || d_chan[m] !== '0 ||
                d_ovf[m] !== '0 || d_full[m] !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got v=%0b d=%h c=%0d ovf=%b full=%b, expected all 0",
                         m, d_valid[m], d_data[m], d_chan[m], d_ovf[m], d_full[m]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                n_tests++;
                if (d_valid[m] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_stale dut%0d cycle %0d: got v=%0b d=%h, expected v=0",
                             m, t, d_valid[m], d_data[m]);
                end
            end
        end
    endtask

    // Write ch0/ch2 on E3 so the fixed-slot pointer is back at 0 on E4.
    task automatic write_pair_at_e3();
        repeat (3) @(posedge clk);
        #1;
        wr_en = 4'b0101;
        wr_data = '0;
        wr_data[0*WIDTH +: WIDTH] = 16'h2933;
        wr_data[2*WIDTH +: WIDTH] = 16'h293F;
        @(posedge clk); #1;
        wr_en = '0;
    endtask

    task automatic test_slots();
        do_reset();
        out_ready = 1'b1;
        write_pair_at_e3();
        @(negedge clk);
        n_tests++;
        if (d_valid[0] !== 1'b0 || d_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL slots_latency: got v0=%0b v1=%0b, expected 0 0", d_valid[0], d_valid[1]);
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (d_valid[m] !== 1'b1 || d_data[m] !== 16'h2933 || d_chan[m] !== 2'd0) begin
                n_fail++;
                $display("FAIL slots_first dut%0d: got v=%0b d=%h c=%0d, expected v=1 d=2933 c=0",
                         m, d_valid[m], d_data[m], d_chan[m]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (d_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed_empty_slot: got v=%0b, expected v=0", d_valid[0]);
        end
        n_tests++;
        if (d_valid[1] !== 1'b1 || d_data[1] !== 16'h293F || d_chan[1] !== 2'd2) begin
            n_fail++;
            $display("FAIL wc_second: got v=%0b d=%h c=%0d, expected v=1 d=293f c=2",
                     d_valid[1], d_data[1], d_chan[1]);
        end
        @(negedge clk);
        n_tests++;
        if (d_valid[0] !== 1'b1 || d_data[0] !== 16'h293F || d_chan[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL fixed_third: got v=%0b d=%h c=%0d, expected v=1 d=293f c=2",
                     d_valid[0], d_data[0], d_chan[0]);
        end
        n_tests++;
        if (d_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL wc_idle: got v=%0b, expected v=0", d_valid[1]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        write_pair_at_e3();
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                n_tests++;
                if (d_valid[m] !== 1'b1 || d_data[m] !== 16'h2933 || d_chan[m] !== 2'd0) begin
                    n_fail++;
                    $display("FAIL bp_hold dut%0d cycle %0d: got v=%0b d=%h c=%0d, expected v=1 d=2933 c=0",
                             m, t, d_valid[m], d_data[m], d_chan[m]);
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (d_valid[1] !== 1'b1 || d_data[1] !== 16'h293F || d_chan[1] !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_wc_release: got v=%0b d=%h c=%0d, expected v=1 d=293f c=2",
                     d_valid[1], d_data[1], d_chan[1]);
        end
        // Fixed mode: the frozen pointer resumes at slot 1 (empty), then slot 2.
        n_tests++;
        if (d_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_fix_slot1: got v=%0b, expected v=0", d_valid[0]);
        end
        @(negedge clk);
        n_tests++;
        if (d_valid[0] !== 1'b1 || d_data[0] !== 16'h293F || d_chan[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_fix_slot2: got v=%0b d=%h c=%0d, expected v=1 d=293f c=2",
                     d_valid[0], d_data[0], d_chan[0]);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] vals [3];
        logic [WIDTH-1:0] got0 [$];
        logic [WIDTH-1:0] got1 [$];
        vals = '{16'h1133, 16'h2803, 16'h88F3};
        do_reset();
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr_en = 4'b0001;
        wr_data[0*WIDTH +: WIDTH] = 16'h0A0A;
        @(posedge clk); #1;
        wr_en = '0;
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (d_valid[m] !== 1'b1 || d_data[m] !== 16'h0A0A) begin
                n_fail++;
                $display("FAIL ovf_precond dut%0d: got v=%0b d=%h, expected v=1 d=0a0a", m, d_valid[m], d_data[m]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            wr_en = 4'b0010;
            wr_data[1*WIDTH +: WIDTH] = vals[i];
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                n_tests++;
                if (d_full[m][1] !== (i >= 1) || d_ovf[m][1] !== (i == 2)) begin
                    n_fail++;
                    $display("FAIL ovf_write%0d dut%0d: got full1=%0b ovf1=%0b, expected full1=%0b ovf1=%0b",
                             i, m, d_full[m][1], d_ovf[m][1], (i >= 1), (i == 2));
                end
            end
        end
        wr_en = '0;
        out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (d_valid[0] === 1'b1 && d_chan[0] === 2'd1) got0.push_back(d_data[0]);
            if (d_valid[1] === 1'b1 && d_chan[1] === 2'd1) got1.push_back(d_data[1]);
        end
        n_tests++;
        if (got0.size() != 2 || got0[0] !== 16'h1133 || got0[1] !== 16'h2803) begin
            n_fail++;
            $display("FAIL ovf_drain dut0: got %0d words %p, expected 1133 2803", got0.size(), got0);
        end
        n_tests++;
        if (got1.size() != 2 || got1[0] !== 16'h1133 || got1[1] !== 16'h2803) begin
            n_fail++;
            $display("FAIL ovf_drain dut1: got %0d words %p, expected 1133 2803", got1.size(), got1);
        end
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (d_ovf[m] !== 4'b0010 || d_full[m] !== 4'b0000) begin
                n_fail++;
                $display("FAIL ovf_sticky dut%0d: got ovf=%b full=%b, expected ovf=0010 full=0000",
                         m, d_ovf[m], d_full[m]);
            end
        end
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_tests++;
            if (d_ovf[m] !== 4'b0000) begin
                n_fail++;
                $display("FAIL ovf_clear dut%0d: got ovf=%b, expected 0000", m, d_ovf[m]);
            end
        end
    endtask

    task automatic test_wrap();
        localparam int NW = 2 * DEPTH + 1;
        logic [WIDTH-1:0] exp_v [CHANNELS][NW];
        int got_n [2][CHANNELS];
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < CHANNELS; c++) got_n[m][c] = 0;
        do_reset();
        out_ready = 1'b1;
        // Edge t writes channel t%4; with continuous drain the fixed-slot output
        // after edge t always comes from slot t%4.
        for (int t = 0; t < NW * CHANNELS + 20; t++) begin
            wr_en = '0;
            if (t < NW * CHANNELS) begin
                wr_en[t % CHANNELS] = 1'b1;
                exp_v[t % CHANNELS][t / CHANNELS] = 16'($urandom);
                wr_data[(t % CHANNELS)*WIDTH +: WIDTH] = exp_v[t % CHANNELS][t / CHANNELS];
            end
            @(posedge clk);
            @(negedge clk);
            if (d_valid[0] === 1'b1) begin
                n_tests++;
                if (int'(d_chan[0]) != t % CHANNELS) begin
                    n_fail++;
                    $display("FAIL wrap_slot cycle %0d: got c=%0d, expected c=%0d", t, d_chan[0], t % CHANNELS);
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (d_valid[m] === 1'b1) begin
                    int c;
                    c = int'(d_chan[m]);
                    n_tests++;
                    if (got_n[m][c] >= NW) begin
                        n_fail++;
                        $display("FAIL wrap_extra dut%0d ch%0d: got d=%h, expected no more words", m, c, d_data[m]);
                    end else if (d_data[m] !== exp_v[c][got_n[m][c]]) begin
                        n_fail++;
                        $display("FAIL wrap_order dut%0d ch%0d word%0d: got %h, expected %h",
                                 m, c, got_n[m][c], d_data[m], exp_v[c][got_n[m][c]]);
                    end
                    got_n[m][c]++;
                end
            end
        end
        wr_en = '0;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                n_tests++;
                if (got_n[m][c] != NW) begin
                    n_fail++;
                    $display("FAIL wrap_count dut%0d ch%0d: got %0d words, expected %0d", m, c, got_n[m][c], NW);
                end
            end
            n_tests++;
            if (d_ovf[m] !== '0) begin
                n_fail++;
                $display("FAIL wrap_ovf dut%0d: got ovf=%b, expected 0000", m, d_ovf[m]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 800; t++) begin
            for (int c = 0; c < CHANNELS; c++) wr_en[c] = ($urandom_range(0, 99) < 40);
            wr_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 99) < 55);
            clr_ovf   = ($urandom_range(0, 99) < 6);
            reset     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                logic [CHANNELS-1:0] mf;
                for (int c = 0; c < CHANNELS; c++) mf[c] = (mq[m][c].size() == DEPTH);
                n_tests++;
                if (d_valid[m] !== mv[m] || d_data[m] !== md[m] || d_chan[m] !== CW'(mc[m])) begin
                    n_fail++;
                    $display("FAIL rand_out dut%0d cycle %0d: got v=%0b d=%h c=%0d, expected v=%0b d=%h c=%0d",
                             m, t, d_valid[m], d_data[m], d_chan[m], mv[m], md[m], mc[m]);
                end
                n_tests++;
                if (d_full[m] !== mf || d_ovf[m] !== movf[m]) begin
                    n_fail++;
                    $display("FAIL rand_flags dut%0d cycle %0d: got full=%b ovf=%b, expected full=%b ovf=%b",
                             m, t, d_full[m], d_ovf[m], mf, movf[m]);
                end
            end
        end
        reset = 1'b0;
        wr_en = '0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        test_reset();
        test_slots();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
